// File: rtl/pueo_trig_sched_pkg.sv
// Shared types and default widths for the beam trigger scheduler and its FIFO.
package pueo_trig_sched_pkg;

    localparam int META_BITS         = 8;
    localparam int DEPTH_DFLT        = 4;
    localparam int TS_BITS_DFLT      = 32;
    localparam int HOLDOFF_BITS_DFLT = 12;
    localparam int STAT_BITS_DFLT    = 16;

    typedef struct packed {
        logic [META_BITS-1:0]    meta;
        logic [TS_BITS_DFLT-1:0] ts;
    } trig_entry_t;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        HOLDOFF  = 2'd2
    } sched_state_t;

    // Pointer index width; a 2-entry FIFO still needs one index bit.
    function automatic int ptr_bits(input int depth);
        if (depth <= 2) begin
            return 1;
        end else begin
            return $clog2(depth);
        end
    endfunction

endpackage

// File: rtl/trig_sched_fifo.sv
// First-word-fall-through FIFO of packed trigger entries; full/empty come from
// read/write pointers carrying one extra wrap bit.
module trig_sched_fifo
    import pueo_trig_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DFLT,
    parameter int WIDTH = META_BITS + TS_BITS_DFLT
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int AW = ptr_bits(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             empty_s;
    logic             full_s;
    logic             wr_en_s;
    logic             rd_en_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign rd_en_s = pop_i && !empty_s;
    assign wr_en_s = push_i && (!full_s || rd_en_s);

    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o = !empty_s;
    assign full_o  = full_s;

    // Next-state for storage and pointers.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Storage and pointer registers; reset empties the queue and clears the head.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/beam_trigger_scheduler.sv
// Trigger holdoff, timestamping and queuing toward the trigger link.
// Optional statistics counters are built when TRIG_SCHED_STATS_EN is defined.
module beam_trigger_scheduler
    import pueo_trig_sched_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DFLT,
    parameter int TS_BITS      = TS_BITS_DFLT,
    parameter int HOLDOFF_BITS = HOLDOFF_BITS_DFLT,
    parameter int STAT_BITS    = STAT_BITS_DFLT
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    enable_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic                    trig_i,
    input  logic [META_BITS-1:0]    meta_i,
    output logic                    trig_valid_o,
    input  logic                    trig_ready_i,
    output logic [META_BITS-1:0]    trig_meta_o,
    output logic [TS_BITS-1:0]      trig_ts_o,
    input  logic                    stats_clr_i,
    output logic [STAT_BITS-1:0]    accepted_o,
    output logic [STAT_BITS-1:0]    dropped_o
);

    localparam int EW = META_BITS + TS_BITS;

    sched_state_t            state_q, state_d;
    logic [HOLDOFF_BITS-1:0] cnt_q, cnt_d;
    logic [TS_BITS-1:0]      ts_q, ts_d;

    logic          fifo_valid_s;
    logic          fifo_full_s;
    logic [EW-1:0] fifo_head_s;
    logic          trig_take_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    assign trig_take_s = (state_q == ARMED) && trig_i;
    assign pop_s       = fifo_valid_s && trig_ready_i;
    assign push_s      = trig_take_s && (!fifo_full_s || pop_s);
    assign drop_s      = trig_take_s && !push_s;

    // Scheduler next state; enable loss always wins and aborts a running holdoff.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ts_d    = ts_q + TS_BITS'(1);
        case (state_q)
            DISABLED: begin
                cnt_d = {HOLDOFF_BITS{1'b0}};
                if (enable_i) begin
                    state_d = ARMED;
                end else begin
                    state_d = DISABLED;
                end
            end
            ARMED: begin
                if (!enable_i) begin
                    state_d = DISABLED;
                    cnt_d   = {HOLDOFF_BITS{1'b0}};
                end else if (trig_i && (holdoff_i != {HOLDOFF_BITS{1'b0}})) begin
                    state_d = HOLDOFF;
                    cnt_d   = holdoff_i;
                end else begin
                    state_d = ARMED;
                end
            end
            HOLDOFF: begin
                if (!enable_i) begin
                    state_d = DISABLED;
                    cnt_d   = {HOLDOFF_BITS{1'b0}};
                end else if (cnt_q == HOLDOFF_BITS'(1)) begin
                    state_d = ARMED;
                    cnt_d   = {HOLDOFF_BITS{1'b0}};
                end else begin
                    state_d = HOLDOFF;
                    cnt_d   = cnt_q - HOLDOFF_BITS'(1);
                end
            end
            default: begin
                state_d = DISABLED;
                cnt_d   = {HOLDOFF_BITS{1'b0}};
            end
        endcase
    end

    // Scheduler state, holdoff counter and free-running timestamp.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= DISABLED;
            cnt_q   <= {HOLDOFF_BITS{1'b0}};
            ts_q    <= {TS_BITS{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_d;
        end
    end

    trig_sched_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push_s),
        .data_i  ({meta_i, ts_q}),
        .pop_i   (pop_s),
        .data_o  (fifo_head_s),
        .valid_o (fifo_valid_s),
        .full_o  (fifo_full_s)
    );

    assign trig_valid_o = fifo_valid_s;
    assign trig_meta_o  = fifo_head_s[EW-1 -: META_BITS];
    assign trig_ts_o    = fifo_head_s[TS_BITS-1:0];

`ifdef TRIG_SCHED_STATS_EN
    logic [STAT_BITS-1:0] acc_q, acc_d;
    logic [STAT_BITS-1:0] drp_q, drp_d;

    // Saturating statistics; a clear beats a same-cycle increment.
    always_comb begin
        acc_d = acc_q;
        drp_d = drp_q;
        if (stats_clr_i) begin
            acc_d = {STAT_BITS{1'b0}};
            drp_d = {STAT_BITS{1'b0}};
        end else begin
            if (push_s && !(&acc_q)) begin
                acc_d = acc_q + STAT_BITS'(1);
            end else begin
                acc_d = acc_q;
            end
            if (drop_s && !(&drp_q)) begin
                drp_d = drp_q + STAT_BITS'(1);
            end else begin
                drp_d = drp_q;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc_q <= {STAT_BITS{1'b0}};
            drp_q <= {STAT_BITS{1'b0}};
        end else begin
            acc_q <= acc_d;
            drp_q <= drp_d;
        end
    end

    assign accepted_o = acc_q;
    assign dropped_o  = drp_q;
`else
    logic unused_stats_s;

    assign unused_stats_s = ^{stats_clr_i, drop_s};
    assign accepted_o     = {STAT_BITS{1'b0}};
    assign dropped_o      = {STAT_BITS{1'b0}};
`endif

endmodule
